// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Two writeback requesters share the single register-file write port.
//   Requester A (load/memory unit) has fixed priority. Requester B (ALU or
//   multi-cycle unit) has a starvation counter. When the counter saturates,
//   the next grant goes to B. The winning write is registered for one cycle
//   and then drives regWEn/rsW/data_W. Writes to x0 are accepted but never
//   enabled.
//
// Optional feature (macro REGFILE_ARB_BYPASS_EN):
//   Adds a forwarding mux for two read ports. It covers the cycle in which
//   the registered write has not yet landed in the register file.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   a_valid/a_ready          requester A handshake
//   a_rd/a_data              requester A destination register and data
//   b_valid/b_ready          requester B handshake
//   b_rd/b_data              requester B destination register and data
//   hold                     freeze arbitration: no grants, counter frozen
//   regWEn/rsW/data_W        registered register-file write port
//   starve_cnt               current B wait count (observability)
//   [bypass] rs1, rs2        read addresses
//   [bypass] rf_data_1/2     register-file read data
//   [bypass] fwd_data_1/2    read data with forwarding applied
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  input  logic              hold,
`ifdef REGFILE_ARB_BYPASS_EN
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [DATA_W-1:0] rf_data_1,
  input  logic [DATA_W-1:0] rf_data_2,
  output logic [DATA_W-1:0] fwd_data_1,
  output logic [DATA_W-1:0] fwd_data_2,
`endif
  output logic              regWEn,
  output logic [ADDR_W-1:0] rsW,
  output logic [DATA_W-1:0] data_W,
  output logic [1:0]        starve_cnt
);

  localparam logic [1:0] C_STARVE_MAX = 2'(STARVE_MAX);

  logic              r_wen;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_starve;

  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_wen_next;

  // Fixed priority to A, except when B has waited long enough. In that case
  // B wins even if A is valid.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (!hold) begin
      if (b_valid && (r_starve == C_STARVE_MAX)) begin
        w_grant_b = 1'b1;
      end else if (a_valid) begin
        w_grant_a = 1'b1;
      end else if (b_valid) begin
        w_grant_b = 1'b1;
      end
    end
  end

  // A granted write to x0 is consumed but never reaches the register file.
  assign w_wen_next = (w_grant_a && (a_rd != '0)) || (w_grant_b && (b_rd != '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen    <= 1'b0;
      r_rd     <= '0;
      r_data   <= '0;
      r_starve <= 2'd0;
    end else begin
      r_wen <= w_wen_next;
      // Address and data keep their previous values when nothing is granted.
      if (w_grant_a) begin
        r_rd   <= a_rd;
        r_data <= a_data;
      end else if (w_grant_b) begin
        r_rd   <= b_rd;
        r_data <= b_data;
      end
      if (!hold) begin
        if (w_grant_b || !b_valid) begin
          r_starve <= 2'd0;
        end else if (r_starve != C_STARVE_MAX) begin
          r_starve <= r_starve + 2'd1;
        end
      end
    end
  end

  assign a_ready    = w_grant_a;
  assign b_ready    = w_grant_b;
  assign regWEn     = r_wen;
  assign rsW        = r_rd;
  assign data_W     = r_data;
  assign starve_cnt = r_starve;

`ifdef REGFILE_ARB_BYPASS_EN
  // The register file only holds the pending write after this cycle ends.
  // Until then, the pending data is forwarded. x0 is never forwarded.
  assign fwd_data_1 = (r_wen && (r_rd == rs1) && (rs1 != '0)) ? r_data : rf_data_1;
  assign fwd_data_2 = (r_wen && (r_rd == rs2) && (rs2 != '0)) ? r_data : rf_data_2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, hold;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd, b_rd, rsW;
  logic [31:0] a_data, b_data, data_W;
  logic        regWEn;
  logic [1:0]  starve_cnt;
`ifdef REGFILE_ARB_BYPASS_EN
  logic [4:0]  rs1, rs2;
  logic [31:0] rf_data_1, rf_data_2, fwd_data_1, fwd_data_2;
`endif

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_rd       (a_rd),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_rd       (b_rd),
    .b_data     (b_data),
    .hold       (hold),
`ifdef REGFILE_ARB_BYPASS_EN
    .rs1        (rs1),
    .rs2        (rs2),
    .rf_data_1  (rf_data_1),
    .rf_data_2  (rf_data_2),
    .fwd_data_1 (fwd_data_1),
    .fwd_data_2 (fwd_data_2),
`endif
    .regWEn     (regWEn),
    .rsW        (rsW),
    .data_W     (data_W),
    .starve_cnt (starve_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 0; b_valid = 0; hold = 0;
    a_rd = 0; b_rd = 0; a_data = 0; b_data = 0;
`ifdef REGFILE_ARB_BYPASS_EN
    rs1 = 0; rs2 = 0; rf_data_1 = 0; rf_data_2 = 0;
`endif
    step(); step();
    total++;
    if ({regWEn, rsW, data_W, starve_cnt} !== 40'd0) begin
      bad++;
      $display("FAIL reset_state: got wen=%b rd=%0d data=%h cnt=%0d, required all zero",
               regWEn, rsW, data_W, starve_cnt);
    end
    rst = 1'b0;
    $display("txn reset: wen=%b rd=%0d data=%h cnt=%0d", regWEn, rsW, data_W, starve_cnt);
  endtask

  task automatic test_a_write();
    a_valid = 1; a_rd = 5'd1; a_data = 32'h12345678;
    #1;
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      bad++;
      $display("FAIL a_write_ready: got a_ready=%b b_ready=%b, required 1 0", a_ready, b_ready);
    end
    step();
    a_valid = 0;
    total++;
    if (regWEn !== 1'b1 || rsW !== 5'd1 || data_W !== 32'h12345678) begin
      bad++;
      $display("FAIL a_write_commit: got wen=%b rd=%0d data=%h, required 1 1 12345678",
               regWEn, rsW, data_W);
    end
    $display("txn a_write: wen=%b rd=%0d data=%h", regWEn, rsW, data_W);
    step();
    total++;
    if (regWEn !== 1'b0 || rsW !== 5'd1 || data_W !== 32'h12345678) begin
      bad++;
      $display("FAIL idle_hold_value: got wen=%b rd=%0d data=%h, required 0 1 12345678",
               regWEn, rsW, data_W);
    end
  endtask

  task automatic test_starvation();
    logic [7:0] exp_a;
    logic [15:0] exp_cnt;
    exp_a   = 8'b0111_0111;          // bit i = A granted in cycle i
    exp_cnt = 16'b11_10_01_00_11_10_01_00; // two bits per cycle
    a_valid = 1; a_rd = 5'd2; a_data = 32'hA0A0A0A0;
    b_valid = 1; b_rd = 5'd3; b_data = 32'hB0B0B0B0;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++;
      if (a_ready !== exp_a[i] || b_ready !== ~exp_a[i] || starve_cnt !== exp_cnt[2*i +: 2]) begin
        bad++;
        $display("FAIL starve_grant[%0d]: got a=%b b=%b cnt=%0d, required a=%b b=%b cnt=%0d",
                 i, a_ready, b_ready, starve_cnt, exp_a[i], ~exp_a[i], exp_cnt[2*i +: 2]);
      end
      step();
      total++;
      if (regWEn !== 1'b1 || rsW !== (exp_a[i] ? 5'd2 : 5'd3)) begin
        bad++;
        $display("FAIL starve_commit[%0d]: got wen=%b rd=%0d, required 1 %0d",
                 i, regWEn, rsW, exp_a[i] ? 2 : 3);
      end
      $display("txn starve cycle %0d: wen=%b rd=%0d data=%h", i, regWEn, rsW, data_W);
    end
    a_valid = 0; b_valid = 0;
  endtask

  task automatic test_x0();
    b_valid = 1; b_rd = 5'd0; b_data = 32'hFFFFFFFF;
    #1;
    total++;
    if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
      bad++;
      $display("FAIL x0_ready: got b_ready=%b a_ready=%b, required 1 0", b_ready, a_ready);
    end
    step();
    b_valid = 0;
    total++;
    if (regWEn !== 1'b0 || rsW !== 5'd0 || data_W !== 32'hFFFFFFFF) begin
      bad++;
      $display("FAIL x0_commit: got wen=%b rd=%0d data=%h, required 0 0 ffffffff",
               regWEn, rsW, data_W);
    end
    $display("txn x0: wen=%b rd=%0d data=%h", regWEn, rsW, data_W);
  endtask

  task automatic test_same_rd();
    a_valid = 1; a_rd = 5'd7; a_data = 32'h00000111;
    b_valid = 1; b_rd = 5'd7; b_data = 32'h00000222;
    step();
    a_valid = 0;
    total++;
    if (regWEn !== 1'b1 || rsW !== 5'd7 || data_W !== 32'h00000111) begin
      bad++;
      $display("FAIL same_rd_first: got wen=%b rd=%0d data=%h, required 1 7 00000111",
               regWEn, rsW, data_W);
    end
    #1;
    total++;
    if (b_ready !== 1'b1) begin
      bad++;
      $display("FAIL same_rd_b_ready: got %b, required 1", b_ready);
    end
    step();
    b_valid = 0;
    total++;
    if (regWEn !== 1'b1 || rsW !== 5'd7 || data_W !== 32'h00000222) begin
      bad++;
      $display("FAIL same_rd_second: got wen=%b rd=%0d data=%h, required 1 7 00000222",
               regWEn, rsW, data_W);
    end
    $display("txn same_rd: wen=%b rd=%0d data=%h", regWEn, rsW, data_W);
  endtask

  task automatic test_hold();
    a_valid = 1; a_rd = 5'd8; a_data = 32'h88888888;
    b_valid = 1; b_rd = 5'd9; b_data = 32'h99999999;
    step();                                  // A granted, count goes to 1
    hold = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_ready[%0d]: got a=%b b=%b, required 0 0", i, a_ready, b_ready);
      end
      step();
      total++;
      if (regWEn !== 1'b0 || starve_cnt !== 2'd1) begin
        bad++;
        $display("FAIL hold_frozen[%0d]: got wen=%b cnt=%0d, required 0 1", i, regWEn, starve_cnt);
      end
      $display("txn hold cycle %0d: wen=%b cnt=%0d", i, regWEn, starve_cnt);
    end
    hold = 0;
    // Resume from count 1: A, A, then forced B.
    step();
    step();
    #1;
    total++;
    if (starve_cnt !== 2'd3 || b_ready !== 1'b1 || a_ready !== 1'b0) begin
      bad++;
      $display("FAIL hold_resume: got cnt=%0d a=%b b=%b, required 3 0 1", starve_cnt, a_ready, b_ready);
    end
    step();
    a_valid = 0; b_valid = 0;
    total++;
    if (regWEn !== 1'b1 || rsW !== 5'd9 || data_W !== 32'h99999999) begin
      bad++;
      $display("FAIL hold_resume_commit: got wen=%b rd=%0d data=%h, required 1 9 99999999",
               regWEn, rsW, data_W);
    end
    $display("txn hold resume: wen=%b rd=%0d data=%h", regWEn, rsW, data_W);
  endtask

  task automatic test_reset_midwrite();
    a_valid = 1; a_rd = 5'd4; a_data = 32'h44444444;
    b_valid = 1; b_rd = 5'd6; b_data = 32'h66666666;
    step();
    a_valid = 0; b_valid = 0;
    total++;
    if (regWEn !== 1'b1 || starve_cnt !== 2'd1) begin
      bad++;
      $display("FAIL midwrite_setup: got wen=%b cnt=%0d, required 1 1", regWEn, starve_cnt);
    end
    rst = 1;
    #1;
    total++;
    if (regWEn !== 1'b0 || starve_cnt !== 2'd0 || rsW !== 5'd0 || data_W !== 32'd0) begin
      bad++;
      $display("FAIL async_reset: got wen=%b cnt=%0d rd=%0d data=%h, required 0 0 0 0",
               regWEn, starve_cnt, rsW, data_W);
    end
    $display("txn async reset: wen=%b cnt=%0d", regWEn, starve_cnt);
    step();
    rst = 0;
  endtask

`ifdef REGFILE_ARB_BYPASS_EN
  task automatic test_bypass();
    rf_data_1 = 32'h0BAD0BAD; rf_data_2 = 32'h55555555;
    rs1 = 5'd0; rs2 = 5'd0;
    a_valid = 1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    step();
    a_valid = 0;
    rs1 = 5'd5;
    #1;
    total++;
    if (fwd_data_1 !== 32'hDEADBEEF || fwd_data_2 !== 32'h55555555) begin
      bad++;
      $display("FAIL bypass_fwd: got f1=%h f2=%h, required deadbeef 55555555", fwd_data_1, fwd_data_2);
    end
    $display("txn bypass: f1=%h f2=%h", fwd_data_1, fwd_data_2);
  endtask
`endif

  initial begin
    test_reset();
    test_a_write();
    test_starvation();
    test_x0();
    test_same_rd();
    test_hold();
    test_reset_midwrite();
`ifdef REGFILE_ARB_BYPASS_EN
    test_bypass();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
